// File: rtl/multi_tap_delay_line_if.sv
// Sample-stream bundle for the multi-tap delay line.
// The mixer side drives it and the delay line consumes it.
interface multi_tap_delay_line_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TAPS   = 4,
  parameter int GAIN_WIDTH = 16
);
  logic                               sample_valid;
  logic signed [DATA_WIDTH-1:0]       in_sample;
  logic [NUM_TAPS*ADDR_WIDTH-1:0]     tap_delay;
  logic [NUM_TAPS*GAIN_WIDTH-1:0]     tap_gain;
  logic signed [GAIN_WIDTH-1:0]       dry_gain;
  logic signed [GAIN_WIDTH-1:0]       feedback_gain;
  logic                               ready;
  logic signed [DATA_WIDTH-1:0]       out_sample;
  logic                               out_sample_valid;
  logic                               sample_dropped;

  modport master (
    output sample_valid, in_sample, tap_delay, tap_gain, dry_gain, feedback_gain,
    input  ready, out_sample, out_sample_valid, sample_dropped
  );

  modport slave (
    input  sample_valid, in_sample, tap_delay, tap_gain, dry_gain, feedback_gain,
    output ready, out_sample, out_sample_valid, sample_dropped
  );
endinterface

// File: rtl/multi_tap_delay_line.sv
// Circular-buffer echo: NUM_TAPS weighted reads time-multiplexed over one BRAM
// read port, a dry path, and feedback of the wet mix written back per sample.
module multi_tap_delay_line #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TAPS   = 4,
  parameter int GAIN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  multi_tap_delay_line_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = DATA_WIDTH + GAIN_WIDTH;
  localparam int GUARD = $clog2(NUM_TAPS + 1);
  localparam int AW    = PW + GUARD;
  localparam int SW    = AW + 1;
  localparam int TW    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int SH    = GAIN_WIDTH - 1;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_READ, S_DRAIN, S_FORM, S_WRITE} state_t;
  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0]        wr_ptr_reg, clear_addr_reg, rd_addr, eff_delay;
  logic [TW-1:0]                tap_cnt_reg, acc_idx_reg;
  logic                         acc_en_reg, out_valid_reg, dropped_reg, accept;
  logic signed [DATA_WIDTH-1:0] x_reg, rd_data_reg, wb_reg, out_sample_reg;
  logic signed [GAIN_WIDTH-1:0] dry_gain_reg, fb_gain_reg;
  logic [ADDR_WIDTH-1:0]        delay_reg [NUM_TAPS];
  logic signed [GAIN_WIDTH-1:0] gain_reg  [NUM_TAPS];
  logic [ADDR_WIDTH-1:0]        delay_in  [NUM_TAPS];
  logic signed [GAIN_WIDTH-1:0] gain_in   [NUM_TAPS];
  logic signed [AW-1:0]         acc_reg, wet_full;
  logic signed [PW-1:0]         tap_prod, dry_prod, fb_prod;
  logic signed [DATA_WIDTH-1:0] wet, out_val, wb_val;
  logic                         mem_we;
  logic [ADDR_WIDTH-1:0]        mem_waddr;
  logic signed [DATA_WIDTH-1:0] mem_wdata;
  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return v[DATA_WIDTH-1:0];
  endfunction

  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_unpack
    assign delay_in[gi] = bus.tap_delay[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign gain_in[gi]  = bus.tap_gain[gi*GAIN_WIDTH +: GAIN_WIDTH];
  end

  assign accept = (state_reg == S_IDLE) && bus.sample_valid;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_CLEAR;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_CLEAR: if (&clear_addr_reg) state_next = S_IDLE;
      S_IDLE:  if (bus.sample_valid) state_next = S_READ;
      S_READ:  if (tap_cnt_reg == TW'(NUM_TAPS - 1)) state_next = S_DRAIN;
      S_DRAIN: state_next = S_FORM;
      S_FORM:  state_next = S_WRITE;
      S_WRITE: state_next = S_IDLE;
      default: state_next = S_CLEAR;
    endcase
  end

  // A zero delay would read the slot about to be written, so it acts as one sample.
  assign eff_delay = (delay_reg[tap_cnt_reg] == '0) ? ADDR_WIDTH'(1) : delay_reg[tap_cnt_reg];
  assign rd_addr   = wr_ptr_reg - eff_delay;

  assign mem_we    = !reset && ((state_reg == S_CLEAR) || (state_reg == S_WRITE));
  assign mem_waddr = (state_reg == S_CLEAR) ? clear_addr_reg : wr_ptr_reg;
  assign mem_wdata = (state_reg == S_CLEAR) ? '0 : wb_reg;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_data_reg <= mem[rd_addr];
  end

  assign tap_prod = PW'(rd_data_reg) * PW'(gain_reg[acc_idx_reg]);
  assign wet_full = acc_reg >>> SH;
  assign wet      = sat(SW'(wet_full));
  assign dry_prod = PW'(x_reg) * PW'(dry_gain_reg);
  assign out_val  = sat(SW'(dry_prod >>> SH) + SW'(wet));
  assign fb_prod  = PW'(wet) * PW'(fb_gain_reg);
  assign wb_val   = sat(SW'(x_reg) + SW'(fb_prod >>> SH));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      clear_addr_reg <= '0;
      tap_cnt_reg    <= '0;
      acc_idx_reg    <= '0;
      acc_en_reg     <= 1'b0;
      acc_reg        <= '0;
      x_reg          <= '0;
      dry_gain_reg   <= '0;
      fb_gain_reg    <= '0;
      wb_reg         <= '0;
      out_sample_reg <= '0;
      out_valid_reg  <= 1'b0;
      dropped_reg    <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        delay_reg[i] <= '0;
        gain_reg[i]  <= '0;
      end
    end else begin
      out_valid_reg <= 1'b0;
      dropped_reg   <= bus.sample_valid && (state_reg != S_IDLE);
      // Read data lags the address by one cycle, so the tap index follows it.
      acc_en_reg    <= (state_reg == S_READ);
      acc_idx_reg   <= tap_cnt_reg;
      if (state_reg == S_CLEAR) clear_addr_reg <= clear_addr_reg + ADDR_WIDTH'(1);
      if (state_reg == S_READ)  tap_cnt_reg <= tap_cnt_reg + TW'(1);
      if (acc_en_reg)           acc_reg <= acc_reg + AW'(tap_prod);
      if (accept) begin
        x_reg        <= bus.in_sample;
        dry_gain_reg <= bus.dry_gain;
        fb_gain_reg  <= bus.feedback_gain;
        tap_cnt_reg  <= '0;
        acc_reg      <= '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
          delay_reg[i] <= delay_in[i];
          gain_reg[i]  <= gain_in[i];
        end
      end
      if (state_reg == S_FORM) begin
        wb_reg         <= wb_val;
        out_sample_reg <= out_val;
        out_valid_reg  <= 1'b1;
      end
      if (state_reg == S_WRITE) wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
    end
  end

  assign bus.ready            = (state_reg == S_IDLE);
  assign bus.out_sample       = out_sample_reg;
  assign bus.out_sample_valid = out_valid_reg;
  assign bus.sample_dropped   = dropped_reg;
endmodule

// File: tb/tb_multi_tap_delay_line.sv
// Bench for multi_tap_delay_line: table of samples with hand-derived outputs,
// checked through a scoreboard queue, plus clear, drop and abort sequences.
module tb_multi_tap_delay_line;
  localparam int A = 4;
  localparam int D = 16;
  localparam int N = 2;
  localparam int G = 16;
  localparam int LAT = N + 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multi_tap_delay_line_if #(.ADDR_WIDTH(A), .DATA_WIDTH(D), .NUM_TAPS(N), .GAIN_WIDTH(G)) bus ();

  multi_tap_delay_line #(.ADDR_WIDTH(A), .DATA_WIDTH(D), .NUM_TAPS(N), .GAIN_WIDTH(G)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit                  rst;
    logic signed [D-1:0] x;
    logic [A-1:0]        d0, d1;
    logic signed [G-1:0] g0, g1, dry, fb;
    logic signed [D-1:0] exp;
  } vec_t;

  typedef struct {
    logic signed [D-1:0] exp;
    int                  acc_cyc;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic signed [D-1:0] last_exp = '0;

  function automatic vec_t mk(bit r, int x, int d0, int g0, int d1, int g1, int dry, int fb, int e);
    vec_t v;
    v.rst = r;   v.x  = D'(x);   v.d0 = A'(d0); v.d1 = A'(d1);
    v.g0  = G'(g0); v.g1 = G'(g1); v.dry = G'(dry); v.fb = G'(fb);
    v.exp = D'(e);
    return v;
  endfunction

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: every output pulse must match the oldest pending expectation.
  initial forever begin
    sb_t e;
    @(negedge clk);
    if (bus.out_sample_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual out_sample=%0d required no pulse", bus.out_sample);
      end else begin
        e = sb_q.pop_front();
        check("out_sample", bus.out_sample, e.exp);
        check("latency", cyc - e.acc_cyc, LAT);
        $display("sample: out=%0d expected=%0d latency=%0d", bus.out_sample, e.exp, cyc - e.acc_cyc);
        last_exp = e.exp;
      end
    end
  end

  task automatic scramble();
    logic [31:0] r0, r1, r2, r3;
    r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
    bus.in_sample     = r0[D-1:0];
    bus.dry_gain      = r0[31:16];
    bus.feedback_gain = r1[G-1:0];
    bus.tap_gain      = r2;
    bus.tap_delay     = r3[N*A-1:0];
  endtask

  task automatic send(input vec_t v, input bit push);
    int w = 0;
    @(negedge clk);
    while (!bus.ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual ready=0 required ready=1 within 200 cycles");
      return;
    end
    bus.in_sample     = v.x;
    bus.tap_delay     = {v.d1, v.d0};
    bus.tap_gain      = {v.g1, v.g0};
    bus.dry_gain      = v.dry;
    bus.feedback_gain = v.fb;
    bus.sample_valid  = 1'b1;
    if (push) sb_q.push_back('{exp: v.exp, acc_cyc: cyc});
    @(negedge clk);
    bus.sample_valid = 1'b0;
    scramble();
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required pending=0", sb_q.size());
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
    check("hold_out_sample", bus.out_sample, last_exp);
  endtask

  task automatic release_clear(input bit probe);
    int cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    check("reset_out_sample", bus.out_sample, 0);
    check("reset_out_valid", bus.out_sample_valid, 0);
    while (cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (probe && cnt == 4) bus.sample_valid = 1'b1;
      if (probe && cnt == 5) begin
        check("clear_drop_pulse", bus.sample_dropped, 1);
        bus.sample_valid = 1'b0;
      end
      if (probe && cnt == 6) check("clear_drop_end", bus.sample_dropped, 0);
      if (bus.ready) break;
    end
    check("clear_cycles", cnt, 1 << A);
    last_exp = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    release_clear(1'b0);
  endtask

  initial begin
    bus.sample_valid  = 1'b0;
    bus.in_sample     = '0;
    bus.tap_delay     = '0;
    bus.tap_gain      = '0;
    bus.dry_gain      = '0;
    bus.feedback_gain = '0;

    // Impulse through taps 3 (x0.5) and 5 (x0.25), dry x0.5.
    vecs.push_back(mk(1, 1000, 3, 'h4000, 5, 'h2000, 'h4000, 0, 500));
    vecs.push_back(mk(0, 0, 3, 'h4000, 5, 'h2000, 'h4000, 0, 0));
    vecs.push_back(mk(0, 0, 3, 'h4000, 5, 'h2000, 'h4000, 0, 0));
    vecs.push_back(mk(0, 0, 3, 'h4000, 5, 'h2000, 'h4000, 0, 500));
    vecs.push_back(mk(0, 0, 3, 'h4000, 5, 'h2000, 'h4000, 0, 0));
    vecs.push_back(mk(0, 0, 3, 'h4000, 5, 'h2000, 'h4000, 0, 250));
    vecs.push_back(mk(0, 0, 3, 'h4000, 5, 'h2000, 'h4000, 0, 0));
    // Feedback x0.5 on a single live tap at delay 2.
    vecs.push_back(mk(1, 1024, 2, 'h4000, 1, 0, 0, 'h4000, 0));
    vecs.push_back(mk(0, 0, 2, 'h4000, 1, 0, 0, 'h4000, 0));
    vecs.push_back(mk(0, 0, 2, 'h4000, 1, 0, 0, 'h4000, 512));
    vecs.push_back(mk(0, 0, 2, 'h4000, 1, 0, 0, 'h4000, 0));
    vecs.push_back(mk(0, 0, 2, 'h4000, 1, 0, 0, 'h4000, 128));
    vecs.push_back(mk(0, 0, 2, 'h4000, 1, 0, 0, 'h4000, 0));
    vecs.push_back(mk(0, 0, 2, 'h4000, 1, 0, 0, 'h4000, 32));
    vecs.push_back(mk(0, 0, 2, 'h4000, 1, 0, 0, 'h4000, 0));
    // Output saturation, positive then negative.
    vecs.push_back(mk(1, 'h7000, 1, 'h7FFF, 1, 0, 'h7FFF, 0, 'h6FFF));
    vecs.push_back(mk(0, 'h7000, 1, 'h7FFF, 1, 0, 'h7FFF, 0, 'h7FFF));
    vecs.push_back(mk(1, -28672, 1, 'h7FFF, 1, 0, 'h7FFF, 0, -28672));
    vecs.push_back(mk(0, -28672, 1, 'h7FFF, 1, 0, 'h7FFF, 0, -32768));
    // Equal delays, floor rounding of negative products.
    vecs.push_back(mk(1, 100, 1, 'h4000, 1, 'h4000, 'h4000, 0, 50));
    vecs.push_back(mk(0, 200, 1, 'h4000, 1, 'h4000, 'h4000, 0, 200));
    vecs.push_back(mk(0, -3, 1, 'h4000, 1, 'h4000, 'h4000, 0, 198));
    vecs.push_back(mk(0, 0, 1, 'h4000, 1, 'h4000, 'h4000, 0, -3));
    // Wet-sum saturation across two full-scale taps.
    vecs.push_back(mk(1, 'h7000, 1, 'h7FFF, 1, 'h7FFF, 0, 'h7FFF, 0));
    vecs.push_back(mk(0, 0, 1, 'h7FFF, 1, 'h7FFF, 0, 'h7FFF, 'h7FFF));

    repeat (3) @(negedge clk);
    check("reset_ready", bus.ready, 0);
    check("reset_out_sample_hold", bus.out_sample, 0);
    check("reset_valid", bus.out_sample_valid, 0);
    check("reset_dropped", bus.sample_dropped, 0);
    release_clear(1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst && i > 0) begin
        drain();
        do_reset();
      end
      send(vecs[i], 1'b1);
    end
    drain();

    // Ramp through a 15-sample tap, pointer wraps more than twice.
    do_reset();
    for (int n = 0; n < 40; n++)
      send(mk(0, 2 * (n + 1), 15, 'h4000, 15, 0, 0, 0, (n >= 15) ? (n - 14) : 0), 1'b1);
    drain();

    // Delay 0 behaves as delay 1.
    do_reset();
    for (int n = 0; n < 40; n++)
      send(mk(0, 2 * (n + 1), 0, 'h4000, 0, 0, 0, 0, (n >= 1) ? n : 0), 1'b1);
    drain();

    // Abort an in-flight sample with reset; a busy strobe is dropped first.
    send(mk(0, 20000, 3, 'h4000, 5, 'h2000, 'h4000, 'h4000, 0), 1'b0);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    check("busy_drop_pulse", bus.sample_dropped, 1);
    reset = 1'b1;
    release_clear(1'b0);
    for (int i = 0; i < 7; i++) send(vecs[i], 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_tap_delay_line.md
Name: multi_tap_delay_line

Overview:
Next-generation audio delay memory. It serves NUM_TAPS independently delayed and weighted read taps from one circular BRAM, plus a dry path and feedback writeback, and yields multi-tap echo in one block. It sits in the effects chain between the voice mixer and the output stage and consumes one sample per sample_valid strobe. It time-multiplexes tap reads over a single BRAM read port and clears memory with a hardware sweep after reset.

Parameters:
ADDR_WIDTH, 16, log2 buffer depth; max delay is 2^ADDR_WIDTH-1 samples.
DATA_WIDTH, 32, signed two's-complement sample width.
NUM_TAPS, 4, number of read taps (1..16).
GAIN_WIDTH, 16, signed Q1.(GAIN_WIDTH-1) gain width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
sample_valid  in  1  input sample strobe
in_sample  in  DATA_WIDTH  signed input sample
tap_delay  in  NUM_TAPS*ADDR_WIDTH  per-tap delay in samples; tap i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
tap_gain  in  NUM_TAPS*GAIN_WIDTH  per-tap signed gain, packed the same way
dry_gain  in  GAIN_WIDTH  signed gain on in_sample
feedback_gain  in  GAIN_WIDTH  signed gain of the wet sum written back into memory
ready  out  1  high only in IDLE; a sample is accepted when sample_valid && ready
out_sample  out  DATA_WIDTH  signed mixed output
out_sample_valid  out  1  one-cycle pulse per accepted sample
sample_dropped  out  1  one-cycle pulse when sample_valid arrives while ready=0

Behaviour:
- Reset sets ready=0, out_sample=0, out_sample_valid=0, sample_dropped=0, wr_ptr=0, and the FSM enters CLEAR.
- Reset mid-operation aborts any in-flight sample with no output pulse.
- CLEAR writes zero to addresses 0..2^ADDR_WIDTH-1 at one address per cycle, then goes to IDLE with ready=1.
- CLEAR lasts 2^ADDR_WIDTH cycles after reset deasserts.
- IDLE: on sample_valid, latch in_sample and all gains/delays, then go to READ. Inputs changing later do not affect that sample.
- READ: cycle k (k=0..NUM_TAPS-1) issues read address wr_ptr - d_k (mod 2^ADDR_WIDTH).
  - d_k = tap_delay_k, clamped to 1 when 0.
  - The BRAM has 1-cycle read latency; the product for tap k accumulates in cycle k+1.
- ACC: one drain cycle for the last tap, then one cycle to form the results:
  - wet = sat(sum_k (mem_k * g_k) >>> (GAIN_WIDTH-1))
  - out = sat(((x*dry_gain) >>> (GAIN_WIDTH-1)) + wet)
  - wb = sat(x + ((wet*feedback_gain) >>> (GAIN_WIDTH-1)))
- Arithmetic rules:
  - Products are full width (DATA_WIDTH+GAIN_WIDTH).
  - The accumulator carries ceil(log2(NUM_TAPS+1)) guard bits.
  - Shifts are arithmetic, truncating toward -inf.
  - sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- WRITE: write wb at wr_ptr, increment wr_ptr (wraps at 2^ADDR_WIDTH), drive out_sample=out, pulse out_sample_valid, return to IDLE; ready=1 the next cycle.
- Latency: out_sample_valid rises exactly NUM_TAPS+3 cycles after the accept cycle. Maximum sample rate is 1 per NUM_TAPS+4 cycles.
- Delay is counted in accepted samples, not clocks. Sample n at tap delay d reads the value written for sample n-d, i.e. x[n-d] plus any feedback added to it.
- Drops: sample_valid while ready=0 (including during CLEAR) is ignored, raises the sample_dropped pulse, and leaves state unchanged.
- out_sample holds its value between pulses.
- Taps with equal delays are legal; each contributes independently.

Test Plan:
- Clear sweep (ADDR_WIDTH=4, NUM_TAPS=2): deassert reset -> ready=0 for 16 cycles then 1. A sample_valid during CLEAR -> sample_dropped=1 for 1 cycle, no out_sample_valid.
- Impulse, no feedback (ADDR_WIDTH=4, DATA_WIDTH=16, GAIN_WIDTH=16): d0=3 g0=0x4000, d1=5 g1=0x2000, dry=0x4000, fb=0; inputs 1000,0,0,... -> outputs 500,0,0,500,0,250,0...
  - Each output valid NUM_TAPS+3=5 cycles after its accept.
- Feedback (NUM_TAPS=1): d0=2 g0=0x4000, dry=0, fb=0x4000; impulse 1024 -> outputs n=2:512, n=4:128, n=6:32, all other n 0.
- Saturation (DATA_WIDTH=16): tap d=1 g=0x7FFF, dry=0x7FFF; inputs 0x7000,0x7000 -> second output 0x7FFF. Negative case with inputs 0x9000,0x9000 -> second output 0x8000.
- Wrap and clamp (ADDR_WIDTH=4): tap d=15 with a ramp input of 40 samples -> out[n]=ramp[n-15] for n>=15, 0 before. Same run with d=0 -> out[n]=ramp[n-1].
- Reset mid-sample: assert reset 2 cycles after accept -> no out_sample_valid, out_sample=0, CLEAR restarts, and later outputs show no residue from the aborted sample.
